// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared state encodings and dead-time sizing for the H-bridge driver
//
// Purpose : state enums for the direction FSM and the per-leg FSM, plus the
//           helper that turns a dead time in ns into a whole number of clocks.
// Ports   : none (package)
package bridge_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    DEAD = 2'd1,
    RUN  = 2'd2
  } top_state_t;

  typedef enum logic [2:0] {
    L_OFF  = 3'd0,
    L_LOW  = 3'd1,
    L_DTH  = 3'd2,
    L_HIGH = 3'd3,
    L_DTL  = 3'd4
  } leg_state_t;

  // Rounds up so the gap is never shorter than requested; at least one
  // cycle so a tiny dead time still separates the two switches.
  function automatic int dead_cycles(input int clock_period_ns, input int dead_time_ns);
    int n;
    n = (dead_time_ns + clock_period_ns - 1) / clock_period_ns;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/bridge_leg.sv
// rtl/bridge_leg.sv - one half-bridge leg with complementary dead-time insertion
//
// Purpose : drives the high/low gate pair of one leg. The low side is the
//           resting state; a request moves to the high side through a dead
//           interval, and dropping the request comes back the same way.
// Ports   : Clock   in  system clock
//           Reset_n in  asynchronous active-low reset
//           LegEn   in  1 = leg may conduct (top FSM will be in RUN)
//           Req     in  1 = high side wanted, 0 = low side wanted
//           High    out registered high-side gate
//           Low     out registered low-side gate
module bridge_leg
  import bridge_pkg::*;
#(
  parameter int DeadCycles = 50
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic LegEn,
  input  logic Req,
  output logic High,
  output logic Low
);

  localparam int              CntW    = $clog2(DeadCycles + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(DeadCycles);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  leg_state_t      r_state;
  leg_state_t      w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            r_high;
  logic            r_low;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= L_OFF;
      r_cnt   <= '0;
      r_high  <= 1'b0;
      r_low   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Gates follow the next state so they change on the same edge as the
      // state itself, without a decode stage after the flops.
      r_high  <= (w_state_next == L_HIGH);
      r_low   <= (w_state_next == L_LOW);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!LegEn) begin
      w_state_next = L_OFF;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        // The top-level DEAD interval already separated any earlier
        // conduction, so the low side can close straight away.
        L_OFF: w_state_next = L_LOW;
        L_LOW: begin
          if (Req) begin
            w_state_next = L_DTH;
            w_cnt_next   = CntLoad;
          end
        end
        L_DTH: begin
          // Request withdrawn before the gap expired: high never turned on,
          // so returning to low needs no further gap.
          if (!Req) begin
            w_state_next = L_LOW;
            w_cnt_next   = '0;
          end else if (r_cnt == CntOne) begin
            w_state_next = L_HIGH;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - CntOne;
          end
        end
        L_HIGH: begin
          if (!Req) begin
            w_state_next = L_DTL;
            w_cnt_next   = CntLoad;
          end
        end
        L_DTL: begin
          if (Req) begin
            w_state_next = L_HIGH;
            w_cnt_next   = '0;
          end else if (r_cnt == CntOne) begin
            w_state_next = L_LOW;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - CntOne;
          end
        end
        default: begin
          w_state_next = L_OFF;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign High = r_high;
  assign Low  = r_low;

endmodule

// File: rtl/hbridge_deadtime_driver.sv
// rtl/hbridge_deadtime_driver.sv - sign-magnitude H-bridge gate driver with dead time
//
// Purpose : turns PWM/Sign/Synch into four gate drives. One leg switches with
//           PWM while the other holds its low side on; direction changes only
//           at a PWM period start and pass through an all-off interval.
// Ports   : Clock   in  system clock
//           Reset_n in  asynchronous active-low reset
//           Enable  in  1 = drive bridge, 0 = all gates off
//           PWM     in  duty signal
//           Synch   in  1-cycle pulse at PWM period start
//           Sign    in  direction request, 0 = leg A switches, 1 = leg B switches
//           HighA   out leg A high-side gate
//           LowA    out leg A low-side gate
//           HighB   out leg B high-side gate
//           LowB    out leg B low-side gate
//           Running out 1 while in RUN
module hbridge_deadtime_driver
  import bridge_pkg::*;
#(
  parameter int ClockPeriod_ns = 20,
  parameter int DeadTime_ns    = 1000
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Enable,
  input  logic PWM,
  input  logic Synch,
  input  logic Sign,
  output logic HighA,
  output logic LowA,
  output logic HighB,
  output logic LowB,
  output logic Running
);

  localparam int              DeadCycles = dead_cycles(ClockPeriod_ns, DeadTime_ns);
  localparam int              CntW       = $clog2(DeadCycles + 1);
  localparam logic [CntW-1:0] CntLoad    = CntW'(DeadCycles);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  logic            r_enable;
  logic            r_pwm;
  logic            r_synch;
  logic            r_sign;

  top_state_t      r_state;
  top_state_t      w_state_next;
  logic            r_dir;
  logic            w_dir_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            r_running;

  logic            w_leg_en;
  logic            w_req_a;
  logic            w_req_b;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_enable <= 1'b0;
      r_pwm    <= 1'b0;
      r_synch  <= 1'b0;
      r_sign   <= 1'b0;
    end else begin
      r_enable <= Enable;
      r_pwm    <= PWM;
      r_synch  <= Synch;
      r_sign   <= Sign;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= OFF;
      r_dir     <= 1'b0;
      r_cnt     <= '0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_dir     <= w_dir_next;
      r_cnt     <= w_cnt_next;
      r_running <= (w_state_next == RUN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dir_next   = r_dir;
    w_cnt_next   = r_cnt;
    case (r_state)
      OFF: begin
        if (r_enable && r_synch) begin
          w_state_next = DEAD;
          w_dir_next   = r_sign;
          w_cnt_next   = CntLoad;
        end
      end
      DEAD: begin
        if (!r_enable) begin
          w_state_next = OFF;
          w_cnt_next   = '0;
        end else if (r_cnt == CntOne) begin
          w_state_next = RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CntOne;
        end
      end
      RUN: begin
        // Enable is checked first so a Synch in the same cycle cannot
        // restart the bridge while it is being shut down.
        if (!r_enable) begin
          w_state_next = OFF;
          w_cnt_next   = '0;
        end else if (r_synch && (r_sign != r_dir)) begin
          w_state_next = DEAD;
          w_dir_next   = r_sign;
          w_cnt_next   = CntLoad;
        end
      end
      default: begin
        w_state_next = OFF;
        w_dir_next   = 1'b0;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Legs are enabled from the next top state so that leaving RUN opens all
  // gates on the very edge the top FSM leaves RUN, not one cycle later.
  assign w_leg_en = (w_state_next == RUN);
  assign w_req_a  = ~r_dir & r_pwm;
  assign w_req_b  = r_dir & r_pwm;

  bridge_leg #(
    .DeadCycles(DeadCycles)
  ) u_leg_a (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .LegEn  (w_leg_en),
    .Req    (w_req_a),
    .High   (HighA),
    .Low    (LowA)
  );

  bridge_leg #(
    .DeadCycles(DeadCycles)
  ) u_leg_b (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .LegEn  (w_leg_en),
    .Req    (w_req_b),
    .High   (HighB),
    .Low    (LowB)
  );

  assign Running = r_running;

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// tb/tb_hbridge_deadtime_driver.sv - self-checking bench for hbridge_deadtime_driver
module tb_hbridge_deadtime_driver;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;
  logic Enable  = 1'b0;
  logic PWM     = 1'b0;
  logic Synch   = 1'b0;
  logic Sign    = 1'b0;
  logic HighA, LowA, HighB, LowB, Running;

  hbridge_deadtime_driver #(
    .ClockPeriod_ns(20),
    .DeadTime_ns   (100)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .Enable (Enable),
    .PWM    (PWM),
    .Synch  (Synch),
    .Sign   (Sign),
    .HighA  (HighA),
    .LowA   (LowA),
    .HighB  (HighB),
    .LowB   (LowB),
    .Running(Running)
  );

  always #10 Clock = ~Clock;

  localparam int DEAD_N = 5;

  // Output bundle {HighA, LowA, HighB, LowB, Running}
  localparam logic [4:0] O_OFF  = 5'b00000;
  localparam logic [4:0] O_LL   = 5'b01011;
  localparam logic [4:0] O_LB   = 5'b00011;
  localparam logic [4:0] O_HALB = 5'b10011;
  localparam logic [4:0] O_LA   = 5'b01001;
  localparam logic [4:0] O_LAHB = 5'b01101;

  typedef struct {
    logic       en;
    logic       pwm;
    logic       syn;
    logic       sgn;
    int         rep;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0] exp;
    int         due;
    int         id;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic last_a = 1'b0;
  logic last_b = 1'b0;
  int   off_a  = 1000;
  int   off_b  = 1000;

  function automatic logic [4:0] outs();
    return {HighA, LowA, HighB, LowB, Running};
  endfunction

  task automatic add(input logic en, input logic pwm, input logic syn, input logic sgn,
                     input int rep, input logic [4:0] exp);
    vec_t v;
    v.en = en; v.pwm = pwm; v.syn = syn; v.sgn = sgn; v.rep = rep; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Tracks one leg's conduction history and checks the gap whenever it
  // conducts on the opposite side from last time.
  task automatic track(input logic hi, input logic lo, input int leg,
                       inout logic last, inout int off);
    if (hi || lo) begin
      if (hi != last) begin
        n_vec++;
        if (off < DEAD_N) begin
          n_fail++;
          $display("FAIL dead_gap leg%0d at cycle %0d: %0d off cycles, need >= %0d",
                   leg, cyc, off, DEAD_N);
        end
      end
      last = hi;
      off  = 0;
    end else begin
      off++;
    end
  endtask

  // One clock: through the active edge to the following falling edge, then
  // checks the invariant, the dead gaps and any scoreboard entries now due.
  task automatic step();
    sb_t e;
    @(posedge Clock);
    @(negedge Clock);
    cyc++;
    n_vec++;
    if ((HighA && LowA) || (HighB && LowB) || (HighA && HighB)) begin
      n_fail++;
      $display("FAIL shoot_through at cycle %0d: outputs %b", cyc, outs());
    end
    track(HighA, LowA, 0, last_a, off_a);
    track(HighB, LowB, 1, last_b, off_b);
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      n_vec++;
      if (outs() !== e.exp) begin
        n_fail++;
        $display("FAIL vector %0d at cycle %0d: got {HA,LA,HB,LB,Run}=%b, expected %b",
                 e.id, cyc, outs(), e.exp);
      end
    end
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    sb_t s;

    // Outputs land two edges after the inputs; each entry's expectation is
    // the output bundle at that point.
    add(0, 0, 0, 0, 3, O_OFF);   // disabled
    add(1, 0, 0, 0, 2, O_OFF);   // enabled, waiting for Synch
    add(1, 0, 1, 0, 1, O_OFF);   // Synch -> DEAD
    add(1, 0, 0, 0, 4, O_OFF);   // rest of the 5 dead cycles
    add(1, 0, 0, 0, 3, O_LL);    // RUN, both lows on
    add(1, 1, 0, 0, 5, O_LB);    // PWM rise: LowA off, 5 dead cycles
    add(1, 1, 0, 0, 3, O_HALB);  // HighA on
    add(1, 0, 0, 0, 5, O_LB);    // PWM fall: HighA off, 5 dead cycles
    add(1, 0, 0, 0, 2, O_LL);    // LowA back
    add(1, 1, 0, 0, 3, O_LB);    // 3-cycle pulse, swallowed
    add(1, 0, 0, 0, 2, O_LL);    // LowA returns at once
    add(1, 0, 1, 0, 1, O_LL);    // Synch with unchanged sign: stay in RUN
    add(1, 0, 0, 1, 2, O_LL);    // sign change without Synch ignored
    add(1, 1, 0, 1, 3, O_LB);    // leg A still switching under old direction
    add(1, 0, 0, 1, 2, O_LL);
    add(1, 0, 1, 1, 1, O_OFF);   // Synch with new sign -> DEAD
    add(1, 0, 0, 1, 4, O_OFF);
    add(1, 0, 0, 1, 2, O_LL);    // RUN reverse
    add(1, 1, 0, 1, 5, O_LA);    // leg B switches: LowB off
    add(1, 1, 0, 1, 2, O_LAHB);  // HighB on
    add(0, 1, 0, 1, 1, O_OFF);   // Enable drop: all off next cycle
    add(1, 1, 0, 1, 8, O_OFF);   // re-enable needs Synch
    add(1, 0, 1, 1, 1, O_OFF);   // Synch -> DEAD
    add(1, 0, 0, 1, 4, O_OFF);
    add(1, 0, 0, 1, 2, O_LL);
    add(0, 0, 1, 0, 1, O_OFF);   // Enable falls with Synch+sign change: OFF
    add(1, 0, 0, 0, 7, O_OFF);   // stays OFF, no Synch seen

    @(negedge Clock);
    check("reset_state", outs(), O_OFF);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        Enable = vecs[i].en;
        PWM    = vecs[i].pwm;
        Synch  = vecs[i].syn;
        Sign   = vecs[i].sgn;
        s.exp  = vecs[i].exp;
        s.due  = cyc + 2;
        s.id   = i;
        sbq.push_back(s);
        step();
      end
    end
    Synch = 1'b0;
    step();
    step();
    n_vec++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    // Asynchronous reset while HighA is on.
    Enable = 1'b1; Sign = 1'b0; PWM = 1'b0; Synch = 1'b1;
    step();
    Synch = 1'b0; PWM = 1'b1;
    for (int k = 0; k < 16; k++) step();
    check("pre_reset_higha", outs(), O_HALB);
    #5;
    Reset_n = 1'b0;
    #1;
    check("async_reset_immediate", outs(), O_OFF);
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int k = 0; k < 8; k++) step();
    check("after_reset_off", outs(), O_OFF);

    // Randomised stress: invariant and dead gaps are checked in step().
    hold = 0;
    for (int k = 0; k < 20000; k++) begin
      if (hold == 0) begin
        PWM  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 14);
      end else begin
        hold--;
      end
      Synch  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) Sign = ~Sign;
      Enable = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
